// File: rtl/vga_mem_pkg.sv
// Shared widths and the return-path owner tag for the VGA/CPU memory arbiter.
package vga_mem_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int DATA_W_DEF = 16;
   localparam int WAIT_W     = 8;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_VGA    = 2'd1,
      OWN_CPU_RD = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_req_slot.sv
// One-entry CPU request buffer with the CPU wait counter; issues only when the
// pixel generator leaves the memory slot free.
module mem_req_slot
   import vga_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vga_req,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              issue,
   output logic              buf_valid,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic [WAIT_W-1:0] wait_cnt
);

   function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic accept;

   // Ready while empty or while the buffer drains this cycle, so issue and
   // reload can share one edge.
   assign cpu_ready = !rst_n || !buf_valid || !vga_req;
   assign issue     = rst_n && buf_valid && !vga_req;
   assign accept    = rst_n && cpu_req && cpu_ready;

   always_ff @(posedge clk) begin
      if (!rst_n)
         buf_valid <= 1'b0;
      else if (accept)
         buf_valid <= 1'b1;
      else if (issue)
         buf_valid <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         buf_we    <= cpu_we;
         buf_addr  <= cpu_addr;
         buf_wdata <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (issue)
         wait_cnt <= '0;
      else if (buf_valid && vga_req)
         wait_cnt <= sat_inc(wait_cnt);
   end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares a single-port memory between a never-stalled pixel generator and a
// buffered CPU port; the owner tag steers read data back to the right client.
module vga_mem_arbiter
   import vga_mem_pkg::*;
#(
   parameter int          ADDR_W       = ADDR_W_DEF,
   parameter int          DATA_W       = DATA_W_DEF,
   parameter logic [7:0]  STARVE_LIMIT = 8'd64
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_starve,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic              issue;
   logic              buf_valid;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_wdata;
   logic [WAIT_W-1:0] wait_cnt;

   owner_e            own_p0;
   owner_e            own_p1;
   logic              rvld_p2;
   logic [DATA_W-1:0] rdata_p2;

   mem_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .vga_req   (vga_req),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ready (cpu_ready),
      .issue     (issue),
      .buf_valid (buf_valid),
      .buf_we    (buf_we),
      .buf_addr  (buf_addr),
      .buf_wdata (buf_wdata),
      .wait_cnt  (wait_cnt)
   );

   // Stage p0: slot owner and memory command
   always_comb begin
      own_p0    = OWN_NONE;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (vga_req) begin
         own_p0   = OWN_VGA;
         mem_addr = vga_addr;
      end else if (issue) begin
         own_p0    = buf_we ? OWN_NONE : OWN_CPU_RD;
         mem_addr  = buf_addr;
         mem_we    = buf_we;
         mem_wdata = buf_wdata;
      end
   end

   // Stage p1: owner of the data now on mem_rdata
   always_ff @(posedge clk) begin
      if (!rst_n)
         own_p1 <= OWN_NONE;
      else
         own_p1 <= own_p0;
   end

   // Stage p2: registered CPU read response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvld_p2  <= 1'b0;
         rdata_p2 <= '0;
      end else begin
         rvld_p2 <= (own_p1 == OWN_CPU_RD);
         if (own_p1 == OWN_CPU_RD)
            rdata_p2 <= mem_rdata;
      end
   end

   assign vga_rdata  = mem_rdata;
   assign cpu_rvalid = rvld_p2;
   assign cpu_rdata  = rdata_p2;
   assign cpu_starve = rst_n && (wait_cnt >= STARVE_LIMIT);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed and randomized bench for vga_mem_arbiter against a queue-based
// transaction model of the arbitration and response timing rules.
module tb_vga_mem_arbiter;

   localparam int AW = 24;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic [DW-1:0] vga_rdata;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_starve;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   always #5 clk = ~clk;

   vga_mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (8'd64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vga_req    (vga_req),
      .vga_addr   (vga_addr),
      .vga_rdata  (vga_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ready  (cpu_ready),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .cpu_starve (cpu_starve),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct packed {
      int            issued;
      logic [DW-1:0] data;
   } rd_t;

   req_t          mbuf[$];
   rd_t           rdq[$];
   int            mwait;
   logic [DW-1:0] mhold;
   logic          m_ready;
   int            cyc;
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic vr, input logic [AW-1:0] va, input logic cr,
                        input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic [DW-1:0] md);
      vga_req   = vr;
      vga_addr  = va;
      cpu_req   = cr;
      cpu_we    = cw;
      cpu_addr  = ca;
      cpu_wdata = cd;
      mem_rdata = md;
   endtask

   // Compare every output with the model for the current cycle.
   task automatic chk();
      logic          rv;
      logic [DW-1:0] rd;
      @(negedge clk);
      m_ready = !rst_n || (mbuf.size() == 0) || !vga_req;
      check("cpu_ready", cpu_ready, m_ready);
      check("cpu_starve", cpu_starve, rst_n && (mwait >= 64));
      check("vga_rdata", vga_rdata, mem_rdata);
      if (!rst_n) begin
         check("mem_we_rst", mem_we, 1'b0);
      end else if (vga_req) begin
         check("mem_addr_vga", mem_addr, vga_addr);
         check("mem_we_vga", mem_we, 1'b0);
      end else if (mbuf.size() != 0) begin
         check("mem_addr_cpu", mem_addr, mbuf[0].addr);
         check("mem_we_cpu", mem_we, mbuf[0].we);
         check("mem_wdata_cpu", mem_wdata, mbuf[0].wdata);
      end else begin
         check("mem_addr_idle", mem_addr, '0);
         check("mem_we_idle", mem_we, 1'b0);
         check("mem_wdata_idle", mem_wdata, '0);
      end
      rv = (rdq.size() != 0) && (rdq[0].issued == cyc - 2);
      rd = rv ? rdq[0].data : mhold;
      check("cpu_rvalid", cpu_rvalid, rv);
      check("cpu_rdata", cpu_rdata, rd);
   endtask

   // Advance the model across the rising edge with the inputs of this cycle.
   task automatic adv();
      req_t r;
      rd_t  t;
      @(posedge clk);
      if (!rst_n) begin
         mbuf.delete();
         rdq.delete();
         mwait = 0;
         mhold = '0;
      end else begin
         if ((rdq.size() != 0) && (rdq[0].issued == cyc - 2)) begin
            mhold = rdq[0].data;
            void'(rdq.pop_front());
         end
         if ((rdq.size() != 0) && (rdq[rdq.size()-1].issued == cyc - 1)) begin
            t = rdq[rdq.size()-1];
            t.data = mem_rdata;
            rdq[rdq.size()-1] = t;
         end
         if (!vga_req && (mbuf.size() != 0)) begin
            r = mbuf.pop_front();
            if (!r.we) begin
               t.issued = cyc;
               t.data   = '0;
               rdq.push_back(t);
            end
            mwait = 0;
         end else if (vga_req && (mbuf.size() != 0)) begin
            mwait = (mwait < 255) ? mwait + 1 : 255;
         end
         if (cpu_req && m_ready) begin
            r.we    = cpu_we;
            r.addr  = cpu_addr;
            r.wdata = cpu_wdata;
            mbuf.push_back(r);
         end
      end
      #1;
      cyc++;
   endtask

   initial begin
      int pulses;
      logic vr;

      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      cyc   = 0;
      mwait = 0;
      mhold = '0;

      // Reset state, with a CPU request that must not be taken.
      drive(1'b0, '0, 1'b1, 1'b0, 24'h000ABC, '0, 16'h5555);
      chk();
      check("rst_ready", cpu_ready, 1'b1);
      check("rst_starve", cpu_starve, 1'b0);
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      chk();
      adv();
      rst_n = 1'b1;

      // Pixel read: address passes straight through, data returns next cycle.
      drive(1'b1, 24'h000100, 1'b0, 1'b0, '0, '0, 16'h0000);
      chk();
      check("vga_addr_0100", mem_addr, 24'h000100);
      check("vga_we_0", mem_we, 1'b0);
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'hBEEF);
      chk();
      check("vga_rdata_beef", vga_rdata, 16'hBEEF);
      adv();

      // CPU read with a free slot.
      drive(1'b0, '0, 1'b1, 1'b0, 24'h002000, '0, 16'h0);
      chk();
      check("rd_ready", cpu_ready, 1'b1);
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      chk();
      check("rd_issue_addr", mem_addr, 24'h002000);
      check("rd_issue_we", mem_we, 1'b0);
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h1234);
      chk();
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      chk();
      check("rd_rvalid", cpu_rvalid, 1'b1);
      check("rd_rdata_1234", cpu_rdata, 16'h1234);
      adv();
      chk();
      check("rd_rvalid_pulse", cpu_rvalid, 1'b0);
      adv();

      // CPU write stalled behind three pixel cycles.
      drive(1'b1, 24'h000200, 1'b1, 1'b1, 24'h000010, 16'h00FF, 16'h0);
      chk();
      adv();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 24'h000201 + i, 1'b1, 1'b1, 24'h000010, 16'h00FF, 16'h0);
         chk();
         check("wr_stall_ready", cpu_ready, 1'b0);
         adv();
      end
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      chk();
      check("wr_issue_we", mem_we, 1'b1);
      check("wr_issue_addr", mem_addr, 24'h000010);
      check("wr_issue_wdata", mem_wdata, 16'h00FF);
      adv();
      for (int i = 0; i < 3; i++) begin
         chk();
         check("wr_no_rvalid", cpu_rvalid, 1'b0);
         adv();
      end

      // Long pixel burst starving a buffered CPU read.
      drive(1'b1, 24'h000300, 1'b1, 1'b0, 24'h003000, '0, 16'h0);
      chk();
      adv();
      for (int i = 0; i < 70; i++) begin
         drive(1'b1, 24'h000300 + i, 1'b0, 1'b0, '0, '0, 16'(i));
         chk();
         adv();
      end
      check("starve_end_burst", cpu_starve, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'hA5A5);
      chk();
      check("starve_issue_addr", mem_addr, 24'h003000);
      adv();
      chk();
      check("starve_cleared", cpu_starve, 1'b0);
      adv();
      repeat (2) begin
         chk();
         adv();
      end

      // Four back-to-back CPU reads.
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 4)
            drive(1'b0, '0, 1'b1, 1'b0, 24'h004000 + i, '0, 16'($urandom));
         else
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'($urandom));
         chk();
         if (i < 4)
            check("b2b_ready", cpu_ready, 1'b1);
         if (cpu_rvalid)
            pulses++;
         adv();
      end
      check("b2b_pulses", pulses, 4);

      // Reset one cycle after a CPU read issues.
      drive(1'b0, '0, 1'b1, 1'b0, 24'h005000, '0, 16'h0);
      chk();
      adv();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      chk();
      check("rstf_issue_addr", mem_addr, 24'h005000);
      adv();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h7777);
      chk();
      check("rstf_ready", cpu_ready, 1'b1);
      adv();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk();
         check("rstf_no_rvalid", cpu_rvalid, 1'b0);
         check("rstf_ready_after", cpu_ready, 1'b1);
         adv();
      end

      // Randomized traffic with periodic long pixel bursts and rare resets.
      for (int i = 0; i < 900; i++) begin
         if ((i % 300) >= 200 && (i % 300) < 275)
            vr = 1'b1;
         else
            vr = ($urandom_range(0, 99) < 50);
         rst_n = ($urandom_range(0, 199) != 0);
         drive(vr, 24'($urandom), ($urandom_range(0, 99) < 60), 1'($urandom),
               24'($urandom), 16'($urandom), 16'($urandom));
         chk();
         adv();
      end
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 16'h0);
      repeat (4) begin
         chk();
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
